// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the opcode field width and the encodings of the supported operations.
// Every opcode not listed here produces a zero result.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [OP_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [OP_W-1:0] ALU_AND = 6'b000010;
    localparam logic [OP_W-1:0] ALU_OR  = 6'b000011;
    localparam logic [OP_W-1:0] ALU_SLT = 6'b000100;
    localparam logic [OP_W-1:0] ALU_MUL = 6'b000101;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Purely combinational ALU function f(a, b, op).
// Ports:
//   a, b   : WIDTH-bit two's-complement operands
//   op     : OP_W-bit operation select (see alu_pkg)
//   result : WIDTH-bit result; zero for any undefined opcode
// ADD/SUB/MUL wrap modulo 2^WIDTH; MUL keeps the low word of the signed product.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    // Operation decode; the low word of a signed product equals that of the
    // unsigned product, so a single WIDTH-bit multiply serves both.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: begin
                if ($signed(a) < $signed(b)) begin
                    result = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    result = {WIDTH{1'b0}};
                end
            end
            ALU_MUL: result = WIDTH'($signed(a) * $signed(b));
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule : alu_core

// File: rtl/alu_operations_five.sv
// Registered execute-stage ALU for the RISC-V pipeline.
// Operands and opcode are captured on a rising edge with load=1; on the next
// rising edge the result register is updated from the captured values and then
// held until a later capture completes. Back-to-back loads give one result per
// cycle.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, active HIGH despite the name
//   load       : capture strobe for ID_EX_A / ID_EX_B / opcode
//   ID_EX_A    : operand A (signed)
//   ID_EX_B    : operand B (signed)
//   opcode     : operation select (see alu_pkg)
//   ALU_result : registered signed result
module alu_operations_five
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ID_EX_A,
    input  logic [WIDTH-1:0] ID_EX_B,
    input  logic [OP_W-1:0]  opcode,
    output logic [WIDTH-1:0] ALU_result
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [OP_W-1:0]  op_r;
    logic             v_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] core_result_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (core_result_s)
    );

    // Capture stage, pending flag and result register; reset wins over load
    // and discards any pending result.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            op_r     <= {OP_W{1'b0}};
            v_r      <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            if (load) begin
                a_r  <= ID_EX_A;
                b_r  <= ID_EX_B;
                op_r <= opcode;
            end
            v_r <= load;
            // Uses the previously captured operands, so a capture on this
            // same edge does not disturb the result being produced.
            if (v_r) begin
                result_r <= core_result_s;
            end
        end
    end

    assign ALU_result = result_r;

endmodule : alu_operations_five

// File: tb/tb_alu_operations_five.sv
// Self-checking bench for alu_operations_five: table-driven single operations
// plus hand-written sequences for back-to-back loads and reset corner cases.
module tb_alu_operations_five;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [5:0]  opcode;
    logic [31:0] ALU_result;

    int checks;
    int errors;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    alu_operations_five #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .ID_EX_A    (ID_EX_A),
        .ID_EX_B    (ID_EX_B),
        .opcode     (opcode),
        .ALU_result (ALU_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic ld);
        opcode  = op;
        ID_EX_A = a;
        ID_EX_B = b;
        load    = ld;
    endtask

    initial begin
        logic [31:0] prev_exp;

        checks = 0;
        errors = 0;
        vecs[0]  = '{ALU_ADD, 32'd10,         32'd5,          32'd15,         "add_10_5"};
        vecs[1]  = '{ALU_SUB, 32'd20,         32'd8,          32'd12,         "sub_20_8"};
        vecs[2]  = '{ALU_SUB, 32'd5,          32'd10,         32'hFFFFFFFB,   "sub_5_10"};
        vecs[3]  = '{ALU_AND, 32'hFF00FF00,   32'h0F0F0F0F,   32'h0F000F00,   "and"};
        vecs[4]  = '{ALU_OR,  32'hFF00FF00,   32'h0F0F0F0F,   32'hFF0FFF0F,   "or"};
        vecs[5]  = '{ALU_SLT, 32'd15,         32'd20,         32'd1,          "slt_15_20"};
        vecs[6]  = '{ALU_SLT, 32'd25,         32'd20,         32'd0,          "slt_25_20"};
        vecs[7]  = '{ALU_SLT, 32'hFFFFFFFF,   32'd1,          32'd1,          "slt_neg1_1"};
        vecs[8]  = '{ALU_MUL, 32'd6,          32'd7,          32'd42,         "mul_6_7"};
        vecs[9]  = '{ALU_MUL, 32'd65536,      32'd65536,      32'd0,          "mul_wrap"};
        vecs[10] = '{6'b111111, 32'hAAAAAAAA, 32'd0,          32'd0,          "op_3f"};
        vecs[11] = '{ALU_ADD, 32'h7FFFFFFF,   32'd1,          32'h80000000,   "add_wrap"};
        vecs[12] = '{ALU_MUL, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   "mul_neg"};
        vecs[13] = '{ALU_SLT, 32'hFFFFFFFB,   32'hFFFFFFFD,   32'd1,          "slt_neg5_neg3"};
        vecs[14] = '{ALU_SLT, 32'd1,          32'hFFFFFFFF,   32'd0,          "slt_1_neg1"};
        vecs[15] = '{6'b000110, 32'd123,      32'd456,        32'd0,          "op_06"};

        // Reset for 5 cycles with a load attempted underneath it.
        rst_n = 1'b1;
        drive(ALU_ADD, 32'd1, 32'd1, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("reset_state", ALU_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1 check("after_release", ALU_result, 32'd0);

        // Single operations: capture edge, result edge, then hold.
        prev_exp = 32'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            @(posedge clk);
            #1 check({vecs[i].name, "_not_early"}, ALU_result, prev_exp);
            @(negedge clk);
            drive(ALU_MUL, 32'hDEADBEEF, 32'h12345678, 1'b0);
            @(posedge clk);
            #1 check(vecs[i].name, ALU_result, vecs[i].exp);
            repeat (2) @(posedge clk);
            #1 check({vecs[i].name, "_held"}, ALU_result, vecs[i].exp);
            prev_exp = vecs[i].exp;
        end

        // Back-to-back loads give in-order results on consecutive cycles.
        @(negedge clk);
        drive(ALU_ADD, 32'd1, 32'd2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(ALU_SUB, 32'd10, 32'd3, 1'b1);
        @(posedge clk);
        #1 check("b2b_0", ALU_result, 32'd3);
        @(negedge clk);
        drive(ALU_MUL, 32'd4, 32'd5, 1'b1);
        @(posedge clk);
        #1 check("b2b_1", ALU_result, 32'd7);
        @(negedge clk);
        drive(ALU_OR, 32'hFFFFFFFF, 32'd0, 1'b0);
        @(posedge clk);
        #1 check("b2b_2", ALU_result, 32'd20);
        repeat (2) @(posedge clk);
        #1 check("b2b_held", ALU_result, 32'd20);

        // Reset one cycle after a load discards the pending result.
        @(negedge clk);
        drive(ALU_ADD, 32'd100, 32'd200, 1'b1);
        @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_after_load", ALU_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rst_after_load_stays", ALU_result, 32'd0);

        // Reset overrides a simultaneous load.
        @(negedge clk);
        drive(ALU_ADD, 32'd7, 32'd8, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rst_overrides_load", ALU_result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_operations_five
